pulse_measure: RTL

Receive-side counterpart of the pulse stretcher used across the design. It takes a level pulse, possibly from another clock domain, and synchronises it into clk. It measures the pulse's high time in clk cycles and emits a one-cycle result strobe when the pulse ends. It rejects glitches shorter than MIN_LEN and flags pulses longer than MAX_LEN. It is used to qualify front-panel, strobe and handshake pulses before they reach CPU/IO logic.

---
 rtl/pulse_pkg.sv | 15 +
 rtl/sync_ff.sv | 26 ++
 rtl/pulse_measure.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse width measurement block.
// State encoding and default glitch/overlong thresholds.
package pulse_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        MEASURE  = 2'd2,
        OVERLONG = 2'd3
    } pm_state_e;

    localparam int PM_MIN_LEN = 4;
    localparam int PM_MAX_LEN = 200;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage level synchroniser for an asynchronous input.
// Resets every stage to RST_VAL so a reset looks like a held level.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the chain; last stage is the clean copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_measure.sv
// Measures the synchronised high time of a level pulse and reports
// accepted widths, glitches and overlong pulses as one-cycle strobes.
module pulse_measure
    import pulse_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int MIN_LEN     = PM_MIN_LEN,
    parameter int MAX_LEN     = PM_MAX_LEN,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic             valid_out,
    output logic [CNT_W-1:0] width_out,
    output logic             glitch_out,
    output logic             overlong_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    pm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             valid_q, valid_d;
    logic             glitch_q, glitch_d;
    logic             over_q, over_d;
    logic             s;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (pulse_in),
        .q_o   (s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, held width and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            width_q  <= '0;
            valid_q  <= 1'b0;
            glitch_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            valid_q  <= valid_d;
            glitch_q <= glitch_d;
            over_q   <= over_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LOW: if (!s) state_d = IDLE;
            IDLE:     if (s) state_d = MEASURE;
            MEASURE: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == MAX_C) begin
                    state_d = OVERLONG;
                end
            end
            OVERLONG: if (!s) state_d = IDLE;
        endcase
    end

    // Counter update and strobe decisions for the next cycle.
    always_comb begin
        cnt_d    = cnt_q;
        width_d  = width_q;
        valid_d  = 1'b0;
        glitch_d = 1'b0;
        over_d   = 1'b0;
        unique case (state_q)
            WAIT_LOW: ;
            IDLE: if (s) cnt_d = ONE_C;
            MEASURE: begin
                if (s) begin
                    if (cnt_q == MAX_C) begin
                        over_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else if (cnt_q >= MIN_C) begin
                    width_d = cnt_q;
                    valid_d = 1'b1;
                end else begin
                    glitch_d = 1'b1;
                end
            end
            OVERLONG: ;
        endcase
    end

    assign busy         = (state_q == MEASURE) || (state_q == OVERLONG);
    assign valid_out    = valid_q;
    assign glitch_out   = glitch_q;
    assign overlong_out = over_q;
    assign width_out    = width_q;

endmodule
